// File: rtl/dequant_zigzag_writer.sv
// dequant_zigzag_writer: takes zig-zag ordered quantized coefficients, dequantizes
// them with a diagonal-dependent power-of-two shift and signed saturation, and
// writes each result to its raster position in the pre-IDCT SRAM region.
module dequant_zigzag_writer #(
    parameter logic [17:0] PRE_IDCT_BASE = 18'd76800,
    parameter int          Y_BLOCK_COLS  = 40,
    parameter int          BLOCK_ROWS    = 30
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Q_select,
    input  logic [15:0] coeff_data,
    input  logic        coeff_valid,
    output logic        coeff_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        block_done,
    output logic        Done
);

    localparam int CW = (Y_BLOCK_COLS > 2) ? $clog2(Y_BLOCK_COLS) : 1;
    localparam int RW = (BLOCK_ROWS > 2) ? $clog2(BLOCK_ROWS) : 1;
    localparam logic [CW-1:0] Y_LAST_COL = CW'(Y_BLOCK_COLS - 1);
    localparam logic [CW-1:0] C_LAST_COL = CW'(Y_BLOCK_COLS / 2 - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(BLOCK_ROWS - 1);
    localparam logic [17:0]   Y_STRIDE   = 18'(Y_BLOCK_COLS * 8);
    localparam logic [17:0]   C_STRIDE   = 18'(Y_BLOCK_COLS * 4);
    localparam logic [17:0]   U_OFF      = 18'(BLOCK_ROWS * 8 * Y_BLOCK_COLS * 8);
    localparam logic [17:0]   V_OFF      = U_OFF + 18'(BLOCK_ROWS * 8 * Y_BLOCK_COLS * 4);

    localparam logic [1:0] SEG_Y = 2'd0, SEG_U = 2'd1, SEG_V = 2'd2;

    // Zig-zag index -> raster position within the 8x8 block, encoded row*8+col.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [5:0]    k;
    logic [CW-1:0] bcol;
    logic [RW-1:0] brow;
    logic [1:0]    seg;
    logic          q_sel;

    logic                accept, last_coeff;
    logic [5:0]          zz;
    logic [2:0]          zz_row, zz_col, shift;
    logic [3:0]          diag;
    logic [CW-1:0]       last_col;
    logic [17:0]         stride, seg_off, line, addr_c;
    logic signed [21:0]  wide;
    logic [15:0]         sat;

    assign accept     = coeff_valid & coeff_ready;
    assign last_col   = (seg == SEG_Y) ? Y_LAST_COL : C_LAST_COL;
    assign last_coeff = (k == 6'd63) && (bcol == C_LAST_COL) && (brow == LAST_ROW) && (seg == SEG_V);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: start from idle, leave RUN on the frame's final accept, one flush cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (accept && last_coeff) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: only RUN takes coefficients
    always_comb begin
        coeff_ready = (state == RUN);
    end

    // Position counters; everything advances only on an accept
    always_ff @(posedge Clock) begin
        if (Reset || (state == IDLE && Start)) begin
            k     <= '0;
            bcol  <= '0;
            brow  <= '0;
            seg   <= SEG_Y;
            q_sel <= Reset ? 1'b0 : Q_select;
        end else if (accept) begin
            k <= k + 6'd1;
            if (k == 6'd63) begin
                if (bcol == last_col) begin
                    bcol <= '0;
                    if (brow == LAST_ROW) begin
                        brow <= '0;
                        seg  <= (seg == SEG_V) ? SEG_Y : seg + 2'd1;
                    end else begin
                        brow <= brow + RW'(1);
                    end
                end else begin
                    bcol <= bcol + CW'(1);
                end
            end
        end
    end

    // Raster address and shift amount for the coefficient currently presented
    always_comb begin
        zz      = ZZ[k];
        zz_row  = zz[5:3];
        zz_col  = zz[2:0];
        diag    = 4'(zz_row) + 4'(zz_col);
        stride  = (seg == SEG_Y) ? Y_STRIDE : C_STRIDE;
        seg_off = (seg == SEG_U) ? U_OFF : (seg == SEG_V) ? V_OFF : 18'd0;
        line    = (18'(brow) << 3) + 18'(zz_row);
        addr_c  = PRE_IDCT_BASE + seg_off + line * stride + (18'(bcol) << 3) + 18'(zz_col);
        if (!q_sel) begin
            case (diag)
                4'd0:       shift = 3'd3;
                4'd1:       shift = 3'd2;
                4'd2, 4'd3: shift = 3'd3;
                4'd4, 4'd5: shift = 3'd4;
                4'd6, 4'd7: shift = 3'd5;
                default:    shift = 3'd6;
            endcase
        end else begin
            case (diag)
                4'd0:       shift = 3'd3;
                4'd1:       shift = 3'd1;
                4'd2, 4'd3: shift = 3'd1;
                4'd4, 4'd5: shift = 3'd2;
                4'd6, 4'd7: shift = 3'd3;
                default:    shift = 3'd4;
            endcase
        end
    end

    // Dequantize at 22 bits (16 + max shift 6) so nothing is lost before clamping
    always_comb begin
        wide = $signed({{6{coeff_data[15]}}, coeff_data}) <<< shift;
        if (wide > 22'sd32767)       sat = 16'h7FFF;
        else if (wide < -22'sd32768) sat = 16'h8000;
        else                         sat = wide[15:0];
    end

    // Registered SRAM write port: an accept on one edge is the write in the next cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            block_done      <= 1'b0;
            Done            <= 1'b0;
        end else begin
            SRAM_we_n  <= ~accept;
            block_done <= accept && (k == 6'd63);
            Done       <= accept && last_coeff;
            if (accept) begin
                SRAM_address    <= addr_c;
                SRAM_write_data <= sat;
            end
        end
    end

endmodule
